// File: rtl/ntru_pkg.sv
// Shared definitions for the NTRU accumulate-update pipeline:
// coefficient width helper, ternary encoding and beat count per polynomial.
package ntru_pkg;

   // Ternary coefficient encoding carried on s_r (2'b10 is reserved and acts as zero)
   localparam logic [1:0] T_ZERO = 2'b00;
   localparam logic [1:0] T_POS  = 2'b01;
   localparam logic [1:0] T_NEG  = 2'b11;

   // Ceiling log2; clog2(Q-1) gives the coefficient width for a power-of-two Q
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // Beats needed to carry n coefficients at m lanes per beat
   function automatic int beats(input int n, input int m);
      return (n + m - 1) / m;
   endfunction

endpackage

// File: rtl/ntru_au_lane.sv
// One lane of the update: y = e + h, e - h or e, selected by the ternary r.
// Arithmetic wraps modulo 2^QB; there is no saturation.
module ntru_au_lane
   import ntru_pkg::*;
#(
   parameter int QB = 11
) (
   input  logic [QB-1:0] e,
   input  logic [QB-1:0] h,
   input  logic [1:0]    r,
   output logic [QB-1:0] y
);

   // Select the h term by the ternary coefficient and add it to e
   always_comb begin
      y = e;
      case (r)
         T_POS:   y = e + h;
         T_NEG:   y = e - h;
         default: y = e;
      endcase
   end

endmodule

// File: rtl/ntru_au_pipe.sv
// NTRU accumulate-update pipeline: m_e[i] = s_e[i] +/- s_h[i] (mod 2^QB),
// one output register plus a one-entry skid buffer.
// Optional macro NTRU_AU_LENCHK_EN adds the beat counter and sticky err_len.
//
// Handshake: a beat transfers on a rising clk edge where valid and ready are
// both high. A source keeps valid and its payload stable until the transfer;
// s_ready is registered and means "skid buffer empty", so it never depends
// combinationally on m_ready.
module ntru_au_pipe
   import ntru_pkg::*;
#(
   parameter int N = 509,
   parameter int Q = 2048,
   parameter int M = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [1:0]                 s_r,
   input  logic [M*clog2(Q-1)-1:0]    s_h,
   input  logic [M*clog2(Q-1)-1:0]    s_e,
   input  logic                       s_last,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [M*clog2(Q-1)-1:0]    m_e,
   output logic                       m_last,
   input  logic                       err_clr,
   output logic                       err_len
);

   localparam int QB    = clog2(Q - 1);
   localparam int DW    = M * QB;
   localparam int BEATS = beats(N, M);

   logic          accept;
   logic          out_take;
   logic [DW-1:0] sum;
   logic          out_valid;
   logic [DW-1:0] out_e;
   logic          out_last;
   logic          skid_valid;
   logic [DW-1:0] skid_e;
   logic          skid_last;
   logic          skid_valid_n;
   logic          s_ready_q;

   assign accept   = s_valid && s_ready_q;
   assign out_take = out_valid && m_ready;

   genvar gi;
   generate
      for (gi = 0; gi < M; gi++) begin : g_lane
         ntru_au_lane #(.QB(QB)) u_lane (
            .e (s_e[gi*QB +: QB]),
            .h (s_h[gi*QB +: QB]),
            .r (s_r),
            .y (sum[gi*QB +: QB])
         );
      end
   endgenerate

   // Skid occupancy after this edge; accept can only happen while the skid is empty
   always_comb begin
      skid_valid_n = skid_valid;
      if (skid_valid)
         skid_valid_n = !out_take;
      else
         skid_valid_n = accept && out_valid && !out_take;
   end

   // Output register and skid buffer: refill output from skid first, else from input
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_e      <= '0;
         out_last   <= 1'b0;
         skid_valid <= 1'b0;
         skid_e     <= '0;
         skid_last  <= 1'b0;
         s_ready_q  <= 1'b0;
      end else begin
         if (skid_valid && out_take) begin
            out_e      <= skid_e;
            out_last   <= skid_last;
            skid_valid <= 1'b0;
         end else if (accept && (!out_valid || out_take)) begin
            out_valid <= 1'b1;
            out_e     <= sum;
            out_last  <= s_last;
         end else if (accept) begin
            skid_valid <= 1'b1;
            skid_e     <= sum;
            skid_last  <= s_last;
         end else if (out_take) begin
            out_valid <= 1'b0;
         end
         s_ready_q <= !skid_valid_n;
      end
   end

   assign s_ready = s_ready_q;
   assign m_valid = out_valid;
   assign m_e     = out_e;
   assign m_last  = out_last;

`ifdef NTRU_AU_LENCHK_EN
   localparam int CW = (BEATS > 1) ? clog2(BEATS) : 1;

   logic [CW-1:0] cnt;
   logic          at_end;
   logic          err_set;
   logic          err_q;

   assign at_end  = (cnt == CW'(BEATS - 1));
   assign err_set = accept && (s_last != at_end);

   // Beat counter and sticky length error; a new error beats a clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         err_q <= 1'b0;
      end else begin
         if (accept)
            cnt <= (s_last || at_end) ? '0 : cnt + 1'b1;
         if (err_set)
            err_q <= 1'b1;
         else if (err_clr)
            err_q <= 1'b0;
      end
   end

   assign err_len = err_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign err_len        = 1'b0;
`endif

endmodule

// File: tb/tb_ntru_au_pipe.sv
// Directed bench for ntru_au_pipe (N=8, Q=2048, M=4): lane arithmetic and wrap,
// stall/skid behaviour, length error flag and reset mid-stream.
module tb_ntru_au_pipe;

   localparam int TN  = 8;
   localparam int TQ  = 2048;
   localparam int TM  = 4;
   localparam int TQB = 11;
   localparam int DW  = TM * TQB;
`ifdef NTRU_AU_LENCHK_EN
   localparam logic LENCHK = 1'b1;
`else
   localparam logic LENCHK = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [1:0]    s_r = 2'b00;
   logic [DW-1:0] s_h = '0;
   logic [DW-1:0] s_e = '0;
   logic          s_last = 1'b0;
   logic          m_valid;
   logic          m_ready = 1'b1;
   logic [DW-1:0] m_e;
   logic          m_last;
   logic          err_clr = 1'b0;
   logic          err_len;

   int tests_run = 0;
   int tests_failed = 0;

   logic [DW:0] exp_q[$];
   logic        mon_v = 1'b0;
   logic [DW:0] mon_d = '0;
   logic        hs_seen = 1'b0;

   ntru_au_pipe #(.N(TN), .Q(TQ), .M(TM)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_r     (s_r),
      .s_h     (s_h),
      .s_e     (s_e),
      .s_last  (s_last),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_e     (m_e),
      .m_last  (m_last),
      .err_clr (err_clr),
      .err_len (err_len)
   );

   // Clock
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] pk(input int a, input int b, input int c, input int d);
      return {11'(d), 11'(c), 11'(b), 11'(a)};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Offer one beat until accepted (bounded), then queue its expected output
   task automatic send(input logic [1:0] r, input logic [DW-1:0] e, input logic [DW-1:0] h,
                       input logic last, input logic [DW-1:0] ex);
      logic acc;
      acc = 1'b0;
      s_valid = 1'b1;
      s_r = r;
      s_e = e;
      s_h = h;
      s_last = last;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         acc = s_ready;
         @(posedge clk);
         #1;
         if (acc) break;
      end
      if (acc) exp_q.push_back({last, ex});
      else check("send_timeout", 0, 1);
      s_valid = 1'b0;
   endtask

   // Output monitor: capture away from the edge, consume on the handshake edge
   always @(posedge clk) begin
      if (rst_n && mon_v && m_ready) begin
         hs_seen = 1'b1;
         if (exp_q.size() == 0) check("extra_beat", 1, 0);
         else check("beat", mon_d, exp_q.pop_front());
      end
   end

   always @(negedge clk) begin
      if (rst_n && mon_v && !hs_seen) begin
         check("hold_valid", m_valid, 1);
         check("hold_data", {m_last, m_e}, mon_d);
      end
      mon_v = m_valid && rst_n;
      mon_d = {m_last, m_e};
      hs_seen = 1'b0;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   logic [DW-1:0] e0, h0, x0, e1, h1, x1, e2, h2, x2, e3, h3, x3;

   initial begin
      // r=+1: 5+3, 2047+1 wraps, 100+200, 1024+1024 wraps
      e0 = pk(5, 2047, 100, 1024); h0 = pk(3, 1, 200, 1024); x0 = pk(8, 0, 300, 0);
      // r=-1: 5-3, 0-1 wraps, 10-20 wraps, 2047-2047
      e1 = pk(5, 0, 10, 2047);     h1 = pk(3, 1, 20, 2047);  x1 = pk(2, 2047, 2038, 0);
      // r=0: pass e
      e2 = pk(5, 0, 7, 2047);      h2 = pk(3, 1, 9, 5);      x2 = pk(5, 0, 7, 2047);
      // r=reserved: pass e
      e3 = pk(5, 1, 9, 0);         h3 = pk(3, 1, 9, 2047);   x3 = pk(5, 1, 9, 0);

      // Reset state
      #3;
      check("rst_m_valid", m_valid, 0);
      check("rst_s_ready", s_ready, 0);
      check("rst_m_e", m_e, 0);
      check("rst_m_last", m_last, 0);
      check("rst_err_len", err_len, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk); check("rel_s_ready_0", s_ready, 0);
      @(negedge clk); check("rel_s_ready_1", s_ready, 1);
      @(posedge clk); #1;

      // Single beat latency, then back-to-back stream at full rate
      send(2'b01, e0, h0, 1'b0, x0);
      @(negedge clk); check("lat1_m_valid", m_valid, 1);
      @(posedge clk); #1;
      send(2'b11, e1, h1, 1'b1, x1);
      send(2'b00, e2, h2, 1'b0, x2);
      check("stream_s_ready", s_ready, 1);
      send(2'b10, e3, h3, 1'b1, x3);
      repeat (4) @(posedge clk);
      #1;
      check("err_after_good", err_len, 0);

      // Stall: m_ready low for 3 cycles while a stream is offered
      m_ready = 1'b0;
      fork
         begin
            send(2'b01, e0, h0, 1'b0, x0);
            send(2'b11, e1, h1, 1'b1, x1);
            send(2'b00, e2, h2, 1'b0, x2);
            send(2'b10, e3, h3, 1'b1, x3);
         end
         begin
            @(negedge clk); check("stall_rdy1", s_ready, 1);
            @(negedge clk); check("stall_rdy2", s_ready, 1);
            @(negedge clk); check("stall_rdy_low", s_ready, 0);
            check("stall_valid", m_valid, 1);
            check("stall_data", {m_last, m_e}, {1'b0, x0});
            @(posedge clk); #1 m_ready = 1'b1;
            @(posedge clk);
            @(negedge clk); check("unstall_rdy", s_ready, 1);
         end
      join
      repeat (6) @(posedge clk);
      #1;
      check("stall_drained", exp_q.size(), 0);

      // Length error flag
      send(2'b01, e0, h0, 1'b1, x0);
      @(negedge clk); check("err_short", err_len, LENCHK);
      @(posedge clk); #1;
      send(2'b01, e0, h0, 1'b0, x0);
      @(negedge clk); check("err_sticky", err_len, LENCHK);
      @(posedge clk); #1 err_clr = 1'b1;
      @(posedge clk); #1 err_clr = 1'b0;
      @(negedge clk); check("err_clr", err_len, 0);
      @(posedge clk); #1 err_clr = 1'b1;
      send(2'b01, e0, h0, 1'b0, x0);
      err_clr = 1'b0;
      @(negedge clk); check("err_set_wins", err_len, LENCHK);
      @(posedge clk); #1 err_clr = 1'b1;
      @(posedge clk); #1 err_clr = 1'b0;
      send(2'b01, e0, h0, 1'b0, x0);
      send(2'b11, e1, h1, 1'b1, x1);
      @(negedge clk); check("err_good_poly", err_len, 0);
      repeat (4) @(posedge clk);
      #1;

      // Reset with two beats in flight (counter left at 1)
      send(2'b00, e2, h2, 1'b0, x2);
      repeat (3) @(posedge clk);
      #1 m_ready = 1'b0;
      send(2'b10, e3, h3, 1'b1, x3);
      send(2'b01, e0, h0, 1'b0, x0);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_m_valid", m_valid, 0);
      check("midrst_s_ready", s_ready, 0);
      check("midrst_m_e", m_e, 0);
      exp_q.delete();
      m_ready = 1'b1;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_no_stale", m_valid, 0);
      check("post_rst_s_ready_0", s_ready, 0);
      @(negedge clk); check("post_rst_s_ready_1", s_ready, 1);
      repeat (3) @(negedge clk);
      check("post_rst_idle", m_valid, 0);
      @(posedge clk); #1;
      send(2'b01, e0, h0, 1'b0, x0);
      send(2'b11, e1, h1, 1'b1, x1);
      @(negedge clk); check("post_rst_cnt_zero", err_len, 0);
      repeat (4) @(posedge clk);
      #1;
      check("final_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
